// File: rtl/lcd_scene_scheduler.sv
// ============================================================================
// lcd_scene_scheduler : frame-synchronous scene select for the SPI LCD path
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_scene_scheduler #(
    parameter int N_SRC          = 8,
    parameter int HOME_SCENE     = 0,
    parameter int DWELL_FRAMES   = 2,
    parameter int TIMEOUT_FRAMES = 600,
    parameter int LCD_W          = 132,
    parameter int LCD_H          = 162
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cnt_x,
    input  logic [7:0]           cnt_y,
    input  logic [16*N_SRC-1:0]  pix_in,
    input  logic                 req_valid,
    input  logic [2:0]           req_scene,
    output logic                 req_ready,
    input  logic                 activity,
    output logic [15:0]          pix_out,
    output logic [2:0]           scene_cur,
    output logic                 busy,
    output logic                 switch_pulse,
    output logic                 timeout_pulse,
    output logic                 req_err
);

    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL_FRAMES);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_FRAMES);
    localparam logic [IW-1:0] IDLE_PRE   = IW'(TIMEOUT_FRAMES - 1);
    localparam logic [2:0]    HOME       = 3'(HOME_SCENE);
    localparam logic [3:0]    N_SRC_W    = 4'(N_SRC);

    generate
        if (N_SRC < 1 || N_SRC > 8) begin : g_bad_n_src
            $error("lcd_scene_scheduler: N_SRC must be 1..8");
        end
        if (DWELL_FRAMES < 1 || TIMEOUT_FRAMES < 1) begin : g_bad_frames
            $error("lcd_scene_scheduler: DWELL_FRAMES and TIMEOUT_FRAMES must be >= 1");
        end
        if (LCD_W < 1 || LCD_W > 256 || LCD_H < 1 || LCD_H > 256) begin : g_bad_geometry
            $error("lcd_scene_scheduler: panel geometry exceeds 8-bit address range");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [2:0]      r_scene,   w_scene_nxt;
    logic [2:0]      r_pending, w_pending_nxt;
    logic [DW-1:0]   r_dwell,   w_dwell_nxt;
    logic [IW-1:0]   r_idle,    w_idle_nxt;
    logic            r_switch,  w_switch_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic            r_err,     w_err_nxt;
    logic            r_at_origin;

    logic            w_origin;
    logic            w_fs;
    logic            w_req_bad;
    logic            w_idle_reach;
    logic            w_timeout_due;

    assign w_origin  = (cnt_x == 8'd0) && (cnt_y == 8'd0);
    assign w_fs      = w_origin && !r_at_origin;
    assign w_req_bad = {1'b0, req_scene} >= N_SRC_W;

    // Timeout is recognised on the frame start that brings the count to its limit.
    assign w_idle_reach  = (r_idle == IDLE_MAX) || (w_fs && (r_idle == IDLE_PRE));
    assign w_timeout_due = w_idle_reach && (r_scene != HOME) && !activity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_scene     <= HOME;
            r_pending   <= HOME;
            r_dwell     <= DWELL_MAX;
            r_idle      <= '0;
            r_switch    <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
            r_at_origin <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_scene     <= w_scene_nxt;
            r_pending   <= w_pending_nxt;
            r_dwell     <= w_dwell_nxt;
            r_idle      <= w_idle_nxt;
            r_switch    <= w_switch_nxt;
            r_timeout   <= w_timeout_nxt;
            r_err       <= w_err_nxt;
            r_at_origin <= w_origin;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_scene_nxt   = r_scene;
        w_pending_nxt = r_pending;
        w_dwell_nxt   = r_dwell;
        w_idle_nxt    = r_idle;
        w_switch_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;
        w_err_nxt     = 1'b0;

        if (w_fs && (r_dwell != DWELL_MAX)) begin
            w_dwell_nxt = r_dwell + 1'b1;
        end

        if (activity) begin
            w_idle_nxt = '0;
        end else if (w_fs && (r_idle != IDLE_MAX)) begin
            w_idle_nxt = r_idle + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (req_scene != r_scene) begin
                        w_pending_nxt = req_scene;
                        w_state_nxt   = S_WAIT;
                    end
                    // A request in hand always beats a coincident timeout.
                    if (w_timeout_due) begin
                        w_idle_nxt = '0;
                    end
                end else if (w_timeout_due) begin
                    w_pending_nxt = HOME;
                    w_state_nxt   = S_WAIT;
                    w_timeout_nxt = 1'b1;
                    w_idle_nxt    = '0;
                end
            end
            S_WAIT: begin
                if (w_fs && (r_dwell >= DWELL_MAX)) begin
                    w_scene_nxt  = r_pending;
                    w_switch_nxt = 1'b1;
                    w_dwell_nxt  = '0;
                    w_idle_nxt   = '0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pix_out = 16'h0000;
        for (int i = 0; i < N_SRC; i++) begin
            if (i == HOME_SCENE) begin
                pix_out = pix_in[16*i +: 16];
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (r_scene == 3'(i)) begin
                pix_out = pix_in[16*i +: 16];
            end
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign busy          = (r_state == S_WAIT);
    assign scene_cur     = r_scene;
    assign switch_pulse  = r_switch;
    assign timeout_pulse = r_timeout;
    assign req_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lcd_scene_scheduler.sv
// ============================================================================
// tb_lcd_scene_scheduler : directed bench with commit scoreboard
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_scene_scheduler;

    localparam int N_SRC = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          cnt_x;
    logic [7:0]          cnt_y;
    logic [16*N_SRC-1:0] pix_in;
    logic                req_valid;
    logic [2:0]          req_scene;
    logic                req_ready;
    logic                activity;
    logic [15:0]         pix_out;
    logic [2:0]          scene_cur;
    logic                busy;
    logic                switch_pulse;
    logic                timeout_pulse;
    logic                req_err;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb_q[$];

    lcd_scene_scheduler #(
        .N_SRC(N_SRC),
        .HOME_SCENE(0),
        .DWELL_FRAMES(2),
        .TIMEOUT_FRAMES(4),
        .LCD_W(132),
        .LCD_H(162)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cnt_x(cnt_x),
        .cnt_y(cnt_y),
        .pix_in(pix_in),
        .req_valid(req_valid),
        .req_scene(req_scene),
        .req_ready(req_ready),
        .activity(activity),
        .pix_out(pix_out),
        .scene_cur(scene_cur),
        .busy(busy),
        .switch_pulse(switch_pulse),
        .timeout_pulse(timeout_pulse),
        .req_err(req_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_pix(input int s);
        return 16'((s + 1) * 16'h1111);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame start: leave the origin for a cycle, then sit on it.
    task automatic fs_edge();
        cnt_x = 8'd5;
        cnt_y = 8'd3;
        tick();
        cnt_x = 8'd0;
        cnt_y = 8'd0;
        tick();
    endtask

    task automatic request(input logic [2:0] s, input string tag);
        req_valid = 1'b1;
        req_scene = s;
        #1;
        check(tag, req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Scoreboard: every switch pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && switch_pulse) begin
            check("sb_pending", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                logic [2:0] e;
                e = sb_q.pop_front();
                check("sb_scene", scene_cur, e);
                check("sb_pix", pix_out, exp_pix(int'(e)));
            end
        end
    end

    initial begin
        for (int i = 0; i < N_SRC; i++) pix_in[16*i +: 16] = exp_pix(i);
        rst = 1'b1; cnt_x = 8'd0; cnt_y = 8'd0;
        req_valid = 1'b0; req_scene = 3'd0; activity = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_scene", scene_cur, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {switch_pulse, timeout_pulse, req_err}, 0);
        check("rst_pix", pix_out, exp_pix(0));
        tick();

        // First commit happens on the first frame start after the address returns home.
        cnt_x = 8'd131; cnt_y = 8'd161;
        tick();
        sb_q.push_back(3'd3);
        request(3'd3, "t1_ready");
        check("t1_busy", busy, 1);
        cnt_x = 8'd0; cnt_y = 8'd0;
        tick();
        check("t1_scene", scene_cur, 3);
        check("t1_switch", switch_pulse, 1);
        check("t1_pix", pix_out, exp_pix(3));
        tick();
        check("t1_switch_off", switch_pulse, 0);

        // Dwell: two frame starts held, commit on the third.
        sb_q.push_back(3'd1);
        request(3'd1, "t2_ready");
        for (int f = 0; f < 2; f++) begin
            fs_edge();
            check("t2_busy", busy, 1);
            check("t2_ready_low", req_ready, 0);
            check("t2_scene_held", scene_cur, 3);
        end
        fs_edge();
        check("t2_scene", scene_cur, 1);
        check("t2_switch", switch_pulse, 1);
        tick();

        // Timeout back to home after four idle frame starts.
        sb_q.push_back(3'd2);
        request(3'd2, "t3_ready");
        fs_edge(); fs_edge(); fs_edge();
        check("t3_scene2", scene_cur, 2);
        activity = 1'b0;
        for (int f = 0; f < 3; f++) begin
            fs_edge();
            check("t3_no_to", timeout_pulse, 0);
        end
        sb_q.push_back(3'd0);
        fs_edge();
        check("t3_to_pulse", timeout_pulse, 1);
        check("t3_to_busy", busy, 1);
        tick();
        check("t3_to_pulse_off", timeout_pulse, 0);
        fs_edge();
        check("t3_home", scene_cur, 0);
        activity = 1'b1;

        // Activity on the third frame start restarts the idle count.
        sb_q.push_back(3'd2);
        request(3'd2, "t3b_ready");
        fs_edge(); fs_edge(); fs_edge();
        activity = 1'b0;
        fs_edge(); fs_edge();
        activity = 1'b1;
        fs_edge();
        activity = 1'b0;
        for (int f = 0; f < 3; f++) begin
            fs_edge();
            check("t3b_no_to", timeout_pulse, 0);
            check("t3b_idle", busy, 0);
        end
        activity = 1'b1;
        check("t3b_scene", scene_cur, 2);

        // Out-of-range and same-scene requests.
        request(3'd7, "t4_ready7");
        check("t4_err7", req_err, 1);
        check("t4_busy7", busy, 0);
        check("t4_scene7", scene_cur, 2);
        tick();
        check("t4_err_off", req_err, 0);
        request(3'd5, "t4_ready5");
        check("t4_err5", req_err, 1);
        tick();
        request(3'd2, "t4_ready_same");
        check("t4_same_busy", busy, 0);
        check("t4_same_err", req_err, 0);
        check("t4_same_sw", switch_pulse, 0);

        // Request coinciding with the timeout frame start wins.
        activity = 1'b0;
        fs_edge(); fs_edge(); fs_edge();
        sb_q.push_back(3'd4);
        cnt_x = 8'd5; cnt_y = 8'd3;
        tick();
        cnt_x = 8'd0; cnt_y = 8'd0;
        req_valid = 1'b1; req_scene = 3'd4;
        tick();
        req_valid = 1'b0;
        check("t5_no_to", timeout_pulse, 0);
        check("t5_busy", busy, 1);
        fs_edge();
        check("t5_scene", scene_cur, 4);
        check("t5_no_to2", timeout_pulse, 0);
        activity = 1'b1;
        tick();

        // Reset while a change is pending discards it.
        request(3'd3, "t6_ready");
        check("t6_busy", busy, 1);
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        check("t6_scene", scene_cur, 0);
        check("t6_busy_off", busy, 0);
        for (int f = 0; f < 4; f++) fs_edge();
        check("t6_no_switch", scene_cur, 0);
        check("t6_sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
